safe_lockstep_sequencer: RTL and testbench
==========================================

Name: safe_lockstep_sequencer

Overview:
- Downstream consumer of the safe-wrapper control register block's outputs.
- Sequences the three cores through three phases: master-only boot, halt/synchronise of the selected core set via debug request, and a lockstep (TMR/DMR) run. It then returns to master-only operation.
- Drives per-core fetch enables, debug requests and voter/comparator enables.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles in WAIT_HALT before abort; must be ≥ 2.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): halt-wait counter width (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- start_i  in  1  level; high = sequencer enabled
- master_core_i  in  3  one-hot master core select
- safe_mode_i  in  1  1 = lockstep requested
- safe_configuration_i  in  2  00 TMR, 01 DMR cores{0,1}, 10 DMR cores{1,2}, 11 reserved
- critical_section_i  in  1  1 = lockstep exit forbidden
- initial_sync_master_i  in  1  master requests sync (level from register)
- end_sw_routine_i  in  1  end of safe routine (level from register)
- core_sleep_i  in  3  per-core halted/sleep status
- core_fetch_en_o  out  3  per-core fetch enable
- debug_req_o  out  3  per-core debug halt request
- lockstep_en_o  out  1  lockstep active
- tmr_vote_en_o  out  1  TMR voter enable
- dmr_cmp_en_o  out  1  DMR comparator enable
- active_cores_o  out  3  latched active-core mask
- sync_done_o  out  1  1-cycle pulse on lockstep entry
- timeout_o  out  1  sticky halt-wait timeout flag
- cfg_err_o  out  1  sticky bad-config flag

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, edge-detect registers 0.
- All outputs are registered; state and outputs update on the same edge.
- start_i rising edge, in IDLE: latch configuration.
  - Latched fields: master, safe_mode, cfg.
  - Mask: safe_mode=0 or cfg=11 → master; 00 → 111; 01 → 011; 10 → 110.
  - Also clear timeout_o and cfg_err_o.
  - If master_core_i is not one-hot: set cfg_err_o and stay in IDLE.
  - Otherwise go to MASTER_RUN.
- initial_sync_master_i and end_sw_routine_i are used as rising-edge events (registered previous value), so a held level does not retrigger.
- IDLE:
  - fetch_en=0, debug_req=0, lockstep outputs 0.
- MASTER_RUN:
  - fetch_en = latched master only.
  - Sync event with latched safe_mode=1 → HALT_REQ.
  - Sync event with safe_mode=0 is ignored.
- HALT_REQ (1 cycle):
  - fetch_en = mask; debug_req = mask; counter cleared.
  - → WAIT_HALT.
- WAIT_HALT:
  - debug_req = mask held; counter increments each cycle.
  - (core_sleep_i & mask) == mask → RELEASE. The halt test takes priority over timeout in the same cycle.
  - Else, counter == TIMEOUT_CYCLES-1 → set timeout_o, debug_req=0, → MASTER_RUN.
- RELEASE (1 cycle):
  - debug_req=0; lockstep_en=1; sync_done_o=1.
  - → LOCKSTEP.
- LOCKSTEP:
  - fetch_en = mask; lockstep_en=1.
  - tmr_vote_en = (cfg==00); dmr_cmp_en = (cfg∈{01,10}).
  - End event with critical_section_i=0 → EXIT.
  - End event with critical_section_i=1: set a pending flag; exit on the first cycle critical_section_i=0.
- EXIT (1 cycle):
  - lockstep/vote/cmp = 0; fetch_en = master; pending cleared.
  - → MASTER_RUN.
- start_i=0 in any state:
  - Next state IDLE; all outputs except the sticky flags cleared next cycle.
  - Takes priority over every other transition.
- active_cores_o = latched mask while not IDLE, else 0.
- Async reset mid-operation returns everything to reset values immediately.

Test Plan:
- Non-safe boot: start=1, master=010, safe_mode=0 → next cycle fetch_en=010; sync pulse ignored; lockstep_en stays 0.
- TMR sync: master=001, safe_mode=1, cfg=00, sync pulse → debug_req=111.
  - core_sleep=111 after 5 cycles → sync_done pulse, then lockstep_en=1, tmr_vote_en=1, fetch_en=111, debug_req=000.
- DMR 10: cfg=10 → active_cores=110, debug_req=110; core0 sleep ignored; dmr_cmp_en=1 in LOCKSTEP.
- Timeout: TIMEOUT_CYCLES=8, core_sleep stuck at 011 with mask 111 → timeout_o=1 exactly 8 cycles after WAIT_HALT entry; debug_req=000; fetch_en=master.
- Critical section: in LOCKSTEP, end pulse while critical_section=1 → remain LOCKSTEP; critical_section falls → EXIT next cycle, then fetch_en=master, lockstep_en=0.
- Abort/config error:
  - start falls during WAIT_HALT → IDLE, all outputs 0 next cycle.
  - start rising with master=011 → cfg_err_o=1, fetch_en stays 000.

Source files
------------

// File: rtl/safe_lockstep_sequencer.sv
// Lockstep sequencer for the three-core safe wrapper.
// Boots on the master core, halts the selected core set through debug
// request, releases it into TMR/DMR lockstep, and returns to master-only
// operation when the safe routine signals completion.
// Every output is a register loaded from the next state, so an output
// always describes the state the sequencer has just entered.

module safe_lockstep_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [2:0] master_core_i,
    input  logic       safe_mode_i,
    input  logic [1:0] safe_configuration_i,
    input  logic       critical_section_i,
    input  logic       initial_sync_master_i,
    input  logic       end_sw_routine_i,
    input  logic [2:0] core_sleep_i,
    output logic [2:0] core_fetch_en_o,
    output logic [2:0] debug_req_o,
    output logic       lockstep_en_o,
    output logic       tmr_vote_en_o,
    output logic       dmr_cmp_en_o,
    output logic [2:0] active_cores_o,
    output logic       sync_done_o,
    output logic       timeout_o,
    output logic       cfg_err_o
);

    // Halt-wait counter width is derived from the timeout.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CFG_TMR    = 2'b00;
    localparam logic [1:0] CFG_DMR_01 = 2'b01;
    localparam logic [1:0] CFG_DMR_12 = 2'b10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MASTER_RUN = 3'd1,
        HALT_REQ   = 3'd2,
        WAIT_HALT  = 3'd3,
        RELEASE    = 3'd4,
        LOCKSTEP   = 3'd5,
        EXIT       = 3'd6
    } state_t;

    // Cores taking part in the run: the master alone unless lockstep is
    // requested with a valid configuration.
    function automatic logic [2:0] core_mask(input logic [2:0] master,
                                             input logic       safe,
                                             input logic [1:0] cfg);
        logic [2:0] m;
        m = master;
        if (safe) begin
            case (cfg)
                CFG_TMR:    m = 3'b111;
                CFG_DMR_01: m = 3'b011;
                CFG_DMR_12: m = 3'b110;
                default:    m = master;
            endcase
        end
        return m;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, sync_q, end_q;
    logic [2:0]       master_q, master_d;
    logic             safe_q, safe_d;
    logic [1:0]       cfg_q, cfg_d;
    logic [2:0]       mask_q, mask_d;
    logic             pend_q, pend_d;
    logic             timeout_q, timeout_d;
    logic             cfg_err_q, cfg_err_d;

    logic [2:0] fetch_d, dbg_d, act_d;
    logic       lock_d, tmr_d, dmr_d, sdone_d;

    logic start_rise, sync_ev, end_ev, all_halted;

    // Register-driven levels are turned into one-shot events here.
    assign start_rise = start_i & ~start_q;
    assign sync_ev    = initial_sync_master_i & ~sync_q;
    assign end_ev     = end_sw_routine_i & ~end_q;
    assign all_halted = (core_sleep_i & mask_q) == mask_q;

    // State, latched configuration, sticky flags and edge-detect history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            sync_q    <= 1'b0;
            end_q     <= 1'b0;
            master_q  <= '0;
            safe_q    <= 1'b0;
            cfg_q     <= '0;
            mask_q    <= '0;
            pend_q    <= 1'b0;
            timeout_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            start_q   <= start_i;
            sync_q    <= initial_sync_master_i;
            end_q     <= end_sw_routine_i;
            master_q  <= master_d;
            safe_q    <= safe_d;
            cfg_q     <= cfg_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            timeout_q <= timeout_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state logic; dropping start_i overrides every other transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        master_d  = master_q;
        safe_d    = safe_q;
        cfg_d     = cfg_q;
        mask_d    = mask_q;
        pend_d    = pend_q;
        timeout_d = timeout_q;
        cfg_err_d = cfg_err_q;

        if (!start_i) begin
            state_d = IDLE;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        master_d  = master_core_i;
                        safe_d    = safe_mode_i;
                        cfg_d     = safe_configuration_i;
                        mask_d    = core_mask(master_core_i, safe_mode_i,
                                              safe_configuration_i);
                        timeout_d = 1'b0;
                        cfg_err_d = 1'b0;
                        if ($onehot(master_core_i)) state_d   = MASTER_RUN;
                        else                        cfg_err_d = 1'b1;
                    end
                end
                MASTER_RUN: begin
                    // Sync requests are meaningless without lockstep.
                    if (sync_ev && safe_q) begin
                        state_d = HALT_REQ;
                        cnt_d   = '0;
                    end
                end
                HALT_REQ: begin
                    cnt_d   = '0;
                    state_d = WAIT_HALT;
                end
                WAIT_HALT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // A set that halts on the last allowed cycle still syncs.
                    if (all_halted) begin
                        state_d = RELEASE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = MASTER_RUN;
                    end
                end
                RELEASE: begin
                    state_d = LOCKSTEP;
                end
                LOCKSTEP: begin
                    // An end request inside a critical section is deferred
                    // until the section closes.
                    if ((end_ev || pend_q) && !critical_section_i) begin
                        state_d = EXIT;
                        pend_d  = 1'b0;
                    end else if (end_ev) begin
                        pend_d = 1'b1;
                    end
                end
                EXIT: begin
                    pend_d  = 1'b0;
                    state_d = MASTER_RUN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output values for the state being entered.
    always_comb begin
        fetch_d = '0;
        dbg_d   = '0;
        lock_d  = 1'b0;
        tmr_d   = 1'b0;
        dmr_d   = 1'b0;
        sdone_d = 1'b0;
        act_d   = (state_d == IDLE) ? 3'b000 : mask_d;
        case (state_d)
            MASTER_RUN, EXIT: begin
                fetch_d = master_d;
            end
            HALT_REQ, WAIT_HALT: begin
                fetch_d = mask_d;
                dbg_d   = mask_d;
            end
            RELEASE: begin
                fetch_d = mask_d;
                lock_d  = 1'b1;
                sdone_d = 1'b1;
            end
            LOCKSTEP: begin
                fetch_d = mask_d;
                lock_d  = 1'b1;
                tmr_d   = (cfg_d == CFG_TMR);
                dmr_d   = (cfg_d == CFG_DMR_01) || (cfg_d == CFG_DMR_12);
            end
            default: begin
                fetch_d = '0;
            end
        endcase
    end

    // Output registers, loaded on the same edge as the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_fetch_en_o <= '0;
            debug_req_o     <= '0;
            lockstep_en_o   <= 1'b0;
            tmr_vote_en_o   <= 1'b0;
            dmr_cmp_en_o    <= 1'b0;
            active_cores_o  <= '0;
            sync_done_o     <= 1'b0;
        end else begin
            core_fetch_en_o <= fetch_d;
            debug_req_o     <= dbg_d;
            lockstep_en_o   <= lock_d;
            tmr_vote_en_o   <= tmr_d;
            dmr_cmp_en_o    <= dmr_d;
            active_cores_o  <= act_d;
            sync_done_o     <= sdone_d;
        end
    end

    assign timeout_o = timeout_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_safe_lockstep_sequencer.sv
// Bench for safe_lockstep_sequencer: a cycle table of stimulus and
// expected outputs, hand-written corner sequences, then random stimulus
// checked against a phase-level model of the sequencer.

module tb_safe_lockstep_sequencer;

    localparam int TO = 8;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start_i, safe_mode_i, critical_section_i;
    logic       initial_sync_master_i, end_sw_routine_i;
    logic [2:0] master_core_i, core_sleep_i;
    logic [1:0] safe_configuration_i;
    logic [2:0] core_fetch_en_o, debug_req_o, active_cores_o;
    logic       lockstep_en_o, tmr_vote_en_o, dmr_cmp_en_o;
    logic       sync_done_o, timeout_o, cfg_err_o;

    safe_lockstep_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .start_i               (start_i),
        .master_core_i         (master_core_i),
        .safe_mode_i           (safe_mode_i),
        .safe_configuration_i  (safe_configuration_i),
        .critical_section_i    (critical_section_i),
        .initial_sync_master_i (initial_sync_master_i),
        .end_sw_routine_i      (end_sw_routine_i),
        .core_sleep_i          (core_sleep_i),
        .core_fetch_en_o       (core_fetch_en_o),
        .debug_req_o           (debug_req_o),
        .lockstep_en_o         (lockstep_en_o),
        .tmr_vote_en_o         (tmr_vote_en_o),
        .dmr_cmp_en_o          (dmr_cmp_en_o),
        .active_cores_o        (active_cores_o),
        .sync_done_o           (sync_done_o),
        .timeout_o             (timeout_o),
        .cfg_err_o             (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    // {fetch, dbg, lock, tmr, dmr, active, sync_done, timeout, cfg_err}
    logic [14:0] outs;
    assign outs = {core_fetch_en_o, debug_req_o, lockstep_en_o, tmr_vote_en_o,
                   dmr_cmp_en_o, active_cores_o, sync_done_o, timeout_o, cfg_err_o};

    typedef struct {
        logic        st;
        logic [2:0]  m;
        logic        sf;
        logic [1:0]  cf;
        logic        cs, sy, en;
        logic [2:0]  sl;
        logic [14:0] exp;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(input logic st, input logic [2:0] m, input logic sf,
                                input logic [1:0] cf, input logic cs, sy, en,
                                input logic [2:0] sl, input logic [2:0] f, d,
                                input logic l, t, dm, input logic [2:0] a,
                                input logic sd, to, ce);
        vec_t v;
        v.st = st; v.m = m; v.sf = sf; v.cf = cf;
        v.cs = cs; v.sy = sy; v.en = en; v.sl = sl;
        v.exp = {f, d, l, t, dm, a, sd, to, ce};
        return v;
    endfunction

    task automatic drive(input logic st, input logic [2:0] m, input logic sf,
                         input logic [1:0] cf, input logic cs, sy, en,
                         input logic [2:0] sl);
        start_i = st; master_core_i = m; safe_mode_i = sf;
        safe_configuration_i = cf; critical_section_i = cs;
        initial_sync_master_i = sy; end_sw_routine_i = en; core_sleep_i = sl;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string nm, input int idx, input logic [14:0] exp);
        n_vec++;
        if (outs !== exp) begin
            n_err++;
            $display("FAIL %s #%0d got %b want %b (fetch,dbg,lock,tmr,dmr,act,sdone,tmo,cerr)",
                     nm, idx, outs, exp);
        end
    endtask

    task automatic run(input string nm, input int idx, input vec_t v);
        drive(v.st, v.m, v.sf, v.cf, v.cs, v.sy, v.en, v.sl);
        check(nm, idx, v.exp);
    endtask

    // ---------------- reference model ----------------
    typedef enum int {P_OFF, P_SOLO, P_HREQ, P_WAIT, P_REL, P_LOCK, P_EXIT} ph_t;
    ph_t        ph;
    logic [2:0] r_master, r_mask;
    logic [1:0] r_cfg;
    logic       r_safe, r_tmo, r_cerr, r_pend;
    logic       p_st, p_sy, p_en;
    int         waited;

    task automatic model_reset();
        ph = P_OFF; r_master = '0; r_mask = '0; r_cfg = '0; r_safe = 1'b0;
        r_tmo = 1'b0; r_cerr = 1'b0; r_pend = 1'b0;
        p_st = 1'b0; p_sy = 1'b0; p_en = 1'b0; waited = 0;
    endtask

    task automatic model_step(input logic st, input logic [2:0] m, input logic sf,
                              input logic [1:0] cf, input logic cs, sy, en,
                              input logic [2:0] sl);
        bit sync_ev, end_ev;
        sync_ev = sy && !p_sy;
        end_ev  = en && !p_en;
        if (!st) begin
            ph = P_OFF;
            r_pend = 1'b0;
        end else begin
            case (ph)
                P_OFF: if (!p_st) begin
                    r_tmo = 1'b0;
                    r_cerr = 1'b0;
                    if ($countones(m) != 1) r_cerr = 1'b1;
                    else begin
                        r_master = m; r_safe = sf; r_cfg = cf;
                        if (!sf || cf == 2'd3) r_mask = m;
                        else if (cf == 2'd0) r_mask = 3'b111;
                        else if (cf == 2'd1) r_mask = 3'b011;
                        else r_mask = 3'b110;
                        ph = P_SOLO;
                    end
                end
                P_SOLO: if (sync_ev && r_safe) ph = P_HREQ;
                P_HREQ: begin waited = 0; ph = P_WAIT; end
                P_WAIT: begin
                    waited++;
                    if ((sl & r_mask) == r_mask) ph = P_REL;
                    else if (waited == TO) begin r_tmo = 1'b1; ph = P_SOLO; end
                end
                P_REL: ph = P_LOCK;
                P_LOCK: begin
                    if (end_ev && cs) r_pend = 1'b1;
                    if ((end_ev || r_pend) && !cs) begin ph = P_EXIT; r_pend = 1'b0; end
                end
                default: ph = P_SOLO;
            endcase
        end
        p_st = st; p_sy = sy; p_en = en;
    endtask

    function automatic logic [14:0] model_out();
        logic [2:0] f, d, a;
        logic l, t, dm, sd;
        f = (ph == P_OFF) ? 3'b000 : ((ph == P_SOLO || ph == P_EXIT) ? r_master : r_mask);
        d = (ph == P_HREQ || ph == P_WAIT) ? r_mask : 3'b000;
        l = (ph == P_REL || ph == P_LOCK);
        t = (ph == P_LOCK) && (r_cfg == 2'd0);
        dm = (ph == P_LOCK) && (r_cfg == 2'd1 || r_cfg == 2'd2);
        a = (ph == P_OFF) ? 3'b000 : r_mask;
        sd = (ph == P_REL);
        return {f, d, l, t, dm, a, sd, r_tmo, r_cerr};
    endfunction

    vec_t tbl[$];

    initial begin
        // inputs: st m sf cf cs sy en sl | outputs: fetch dbg lock tmr dmr act sdone tmo cerr
        tbl.push_back(mk(0,3'b000,0,2'b00,0,0,0,3'b000, 3'b000,3'b000,0,0,0,3'b000,0,0,0));
        // non-safe boot; sync ignored
        tbl.push_back(mk(1,3'b010,0,2'b00,0,0,0,3'b000, 3'b010,3'b000,0,0,0,3'b010,0,0,0));
        tbl.push_back(mk(1,3'b010,0,2'b00,0,1,0,3'b000, 3'b010,3'b000,0,0,0,3'b010,0,0,0));
        tbl.push_back(mk(1,3'b010,0,2'b00,0,0,0,3'b000, 3'b010,3'b000,0,0,0,3'b010,0,0,0));
        tbl.push_back(mk(0,3'b010,0,2'b00,0,0,0,3'b000, 3'b000,3'b000,0,0,0,3'b000,0,0,0));
        // TMR boot, sync, halt after a few cycles
        tbl.push_back(mk(1,3'b001,1,2'b00,0,0,0,3'b000, 3'b001,3'b000,0,0,0,3'b111,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b00,0,1,0,3'b000, 3'b111,3'b111,0,0,0,3'b111,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b00,0,1,0,3'b000, 3'b111,3'b111,0,0,0,3'b111,0,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1,3'b001,1,2'b00,0,0,0,3'b000, 3'b111,3'b111,0,0,0,3'b111,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b00,0,0,0,3'b111, 3'b111,3'b000,1,0,0,3'b111,1,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b00,0,0,0,3'b111, 3'b111,3'b000,1,1,0,3'b111,0,0,0));
        // end request inside critical section is deferred
        tbl.push_back(mk(1,3'b001,1,2'b00,1,0,1,3'b111, 3'b111,3'b000,1,1,0,3'b111,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b00,1,0,1,3'b111, 3'b111,3'b000,1,1,0,3'b111,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b00,0,0,0,3'b111, 3'b001,3'b000,0,0,0,3'b111,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b00,0,0,0,3'b111, 3'b001,3'b000,0,0,0,3'b111,0,0,0));
        // timeout: core2 never halts, 8 cycles after WAIT_HALT entry
        tbl.push_back(mk(1,3'b001,1,2'b00,0,1,0,3'b011, 3'b111,3'b111,0,0,0,3'b111,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b00,0,0,0,3'b011, 3'b111,3'b111,0,0,0,3'b111,0,0,0));
        for (int i = 0; i < TO - 1; i++)
            tbl.push_back(mk(1,3'b001,1,2'b00,0,0,0,3'b011, 3'b111,3'b111,0,0,0,3'b111,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b00,0,0,0,3'b011, 3'b001,3'b000,0,0,0,3'b111,0,1,0));
        // abort during WAIT_HALT
        tbl.push_back(mk(1,3'b001,1,2'b00,0,1,0,3'b000, 3'b111,3'b111,0,0,0,3'b111,0,1,0));
        tbl.push_back(mk(1,3'b001,1,2'b00,0,0,0,3'b000, 3'b111,3'b111,0,0,0,3'b111,0,1,0));
        tbl.push_back(mk(0,3'b001,1,2'b00,0,0,0,3'b000, 3'b000,3'b000,0,0,0,3'b000,0,1,0));
        // bad master select
        tbl.push_back(mk(1,3'b011,1,2'b00,0,0,0,3'b000, 3'b000,3'b000,0,0,0,3'b000,0,0,1));
        tbl.push_back(mk(1,3'b011,1,2'b00,0,0,0,3'b000, 3'b000,3'b000,0,0,0,3'b000,0,0,1));
        tbl.push_back(mk(0,3'b011,1,2'b00,0,0,0,3'b000, 3'b000,3'b000,0,0,0,3'b000,0,0,1));
        // DMR cores{1,2}: core0 status is irrelevant
        tbl.push_back(mk(1,3'b001,1,2'b10,0,0,0,3'b000, 3'b001,3'b000,0,0,0,3'b110,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b10,0,1,0,3'b000, 3'b110,3'b110,0,0,0,3'b110,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b10,0,0,0,3'b001, 3'b110,3'b110,0,0,0,3'b110,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b10,0,0,0,3'b101, 3'b110,3'b110,0,0,0,3'b110,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b10,0,0,0,3'b110, 3'b110,3'b000,1,0,0,3'b110,1,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b10,0,0,0,3'b110, 3'b110,3'b000,1,0,1,3'b110,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b10,0,0,1,3'b110, 3'b001,3'b000,0,0,0,3'b110,0,0,0));
        tbl.push_back(mk(1,3'b001,1,2'b10,0,0,0,3'b110, 3'b001,3'b000,0,0,0,3'b110,0,0,0));

        rst_ni = 1'b0;
        start_i = 0; master_core_i = '0; safe_mode_i = 0; safe_configuration_i = '0;
        critical_section_i = 0; initial_sync_master_i = 0; end_sw_routine_i = 0;
        core_sleep_i = '0;
        repeat (3) @(posedge clk_i);
        #1 check("reset", 0, 15'd0);
        @(negedge clk_i) rst_ni = 1'b1;

        foreach (tbl[i]) run("table", i, tbl[i]);

        // Halt completes on the very cycle the timeout would fire.
        run("prio", 0, mk(1,3'b001,1,2'b10,0,1,0,3'b000, 3'b110,3'b110,0,0,0,3'b110,0,0,0));
        run("prio", 1, mk(1,3'b001,1,2'b10,0,0,0,3'b000, 3'b110,3'b110,0,0,0,3'b110,0,0,0));
        for (int i = 0; i < TO - 1; i++)
            run("prio", 2 + i, mk(1,3'b001,1,2'b10,0,0,0,3'b000, 3'b110,3'b110,0,0,0,3'b110,0,0,0));
        run("prio", 9, mk(1,3'b001,1,2'b10,0,0,0,3'b110, 3'b110,3'b000,1,0,0,3'b110,1,0,0));
        run("prio", 10, mk(1,3'b001,1,2'b10,0,0,0,3'b110, 3'b110,3'b000,1,0,1,3'b110,0,0,0));

        // Asynchronous reset in the middle of lockstep clears at once.
        #2 rst_ni = 1'b0;
        #1 check("async_rst", 0, 15'd0);
        start_i = 0; initial_sync_master_i = 0; end_sw_routine_i = 0;
        @(negedge clk_i) rst_ni = 1'b1;
        model_reset();

        for (int c = 0; c < 3000; c++) begin
            logic st, sf, cs, sy, en;
            logic [2:0] m, sl;
            logic [1:0] cf;
            st = ($urandom_range(99) < 97);
            m  = ($urandom_range(9) < 9) ? 3'(3'b001 << $urandom_range(2)) : 3'($urandom);
            sf = ($urandom_range(3) != 0);
            cf = 2'($urandom);
            cs = ($urandom_range(9) < 3);
            sy = ($urandom_range(9) < 2);
            en = ($urandom_range(9) < 2);
            sl = ($urandom_range(9) < 3) ? 3'b111 : 3'($urandom);
            drive(st, m, sf, cf, cs, sy, en, sl);
            model_step(st, m, sf, cf, cs, sy, en, sl);
            check("random", c, model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
